ps2_pad_responder: RTL and testbench

Controller-side (responder) end of the PS2 pad serial link. Emulates a digital PS2 pad for the team's host-side controller poller and for board-to-board loopback. Samples the host's ATT/CLK/CMD lines, shifts the 5-byte digital-mode poll response out on DAT LSB-first, and pulses ACK after each byte. Sits between the GPIO pins and a button-source register.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_sync.sv | 51 +++++
 rtl/ps2_pad_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_pad_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package : ps2_pkg
// Brief   : Shared constants, state type and tx-byte selector for the PS2 pad.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

  localparam logic [7:0]  PS2_CMD_START   = 8'h01;
  localparam logic [7:0]  PS2_CMD_POLL    = 8'h42;
  localparam logic [7:0]  PS2_READY       = 8'h5A;
  localparam int unsigned PS2_FRAME_BYTES = 5;

  localparam logic [7:0]  PS2_IDLE_BYTE   = 8'hFF;
  localparam logic [2:0]  PS2_LAST_BYTE   = 3'(PS2_FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    ACK_WAIT  = 3'd2,
    ACK_PULSE = 3'd3,
    ABORT     = 3'd4,
    DONE      = 3'd5
  } ps2_state_e;

  // Response byte for a given position in the digital-mode poll frame.
  function automatic logic [7:0] ps2_tx_byte(
    input logic [2:0]  idx,
    input logic [7:0]  pad_id,
    input logic [15:0] snap
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = PS2_IDLE_BYTE;
      3'd1:    b = pad_id;
      3'd2:    b = PS2_READY;
      3'd3:    b = snap[7:0];
      default: b = snap[15:8];
    endcase
    return b;
  endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
// Module  : ps2_sync
// Brief   : Two-flop synchronizer with registered rise/fall pulses.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Edge pulses compare the two stages so they line up with sync_q,
  // keeping pin-to-action latency at three cycles.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    rise_d = meta_q & ~sync_q;
    fall_d = ~meta_q & sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule : ps2_sync
`default_nettype wire

// File: rtl/ps2_pad_responder.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pad_responder
// Brief   : PS2 digital pad emulator answering the 5-byte host poll frame.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_pad_responder
  import ps2_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 100,
  parameter int unsigned ACK_WIDTH = 150,
  parameter logic [7:0]  PAD_ID    = 8'h41
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [15:0] buttons_n,
  input  logic        ps_att_n,
  input  logic        ps_clk,
  input  logic        ps_cmd,
  output logic        ps_dat,
  output logic        ps_ack_n,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        busy
);

  localparam logic [7:0] C_DELAY_LAST = 8'(ACK_DELAY);
  localparam logic [7:0] C_WIDTH_LAST = 8'(ACK_WIDTH - 1);

  logic w_att_sync, w_att_rise, w_att_fall;
  logic w_clk_sync, w_clk_rise, w_clk_fall;
  logic w_cmd_sync, w_cmd_rise, w_cmd_fall;
  logic w_unused;

  ps2_sync #(.RESET_VAL(1'b1)) u_sync_att (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .async_in (ps_att_n),
    .sync_out (w_att_sync),
    .rise     (w_att_rise),
    .fall     (w_att_fall)
  );

  ps2_sync #(.RESET_VAL(1'b1)) u_sync_clk (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .async_in (ps_clk),
    .sync_out (w_clk_sync),
    .rise     (w_clk_rise),
    .fall     (w_clk_fall)
  );

  ps2_sync #(.RESET_VAL(1'b1)) u_sync_cmd (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .async_in (ps_cmd),
    .sync_out (w_cmd_sync),
    .rise     (w_cmd_rise),
    .fall     (w_cmd_fall)
  );

  assign w_unused = ^{w_att_sync, w_clk_sync, w_cmd_rise, w_cmd_fall};

  ps2_state_e  state_q,     state_d;
  logic [2:0]  byte_idx_q,  byte_idx_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic [7:0]  tx_q,        tx_d;
  logic [7:0]  rx_q,        rx_d;
  logic [15:0] snap_q,      snap_d;
  logic        dat_q,       dat_d;
  logic        ack_n_q,     ack_n_d;
  logic [7:0]  cmd_byte_q,  cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        busy_q,      busy_d;

  logic [7:0]  w_rx_next;
  logic [2:0]  w_byte_next;
  logic        w_bad_header;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    snap_d      = snap_q;
    dat_d       = dat_q;
    ack_n_d     = ack_n_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;

    w_rx_next            = rx_q;
    w_rx_next[bit_idx_q] = w_cmd_sync;
    w_byte_next  = (byte_idx_q == PS2_LAST_BYTE) ? byte_idx_q : byte_idx_q + 3'd1;
    w_bad_header = ((byte_idx_q == 3'd0) && (w_rx_next != PS2_CMD_START)) ||
                   ((byte_idx_q == 3'd1) && (w_rx_next != PS2_CMD_POLL));

    unique case (state_q)
      IDLE: begin
        if (w_att_fall) begin
          state_d    = SHIFT;
          snap_d     = buttons_n;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = 8'd0;
          rx_d       = 8'd0;
          tx_d       = ps2_tx_byte(3'd0, PAD_ID, buttons_n);
          busy_d     = 1'b1;
        end
      end

      SHIFT: begin
        if (w_clk_fall) begin
          dat_d = tx_q[bit_idx_q];
        end
        if (w_clk_rise) begin
          rx_d      = w_rx_next;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            cmd_byte_d  = w_rx_next;
            cmd_valid_d = 1'b1;
            cnt_d       = 8'd0;
            if (w_bad_header) begin
              state_d = ABORT;
              dat_d   = 1'b1;
              busy_d  = 1'b0;
            end else if (byte_idx_q == PS2_LAST_BYTE) begin
              // The protocol gives no ACK after the final byte.
              state_d = DONE;
              dat_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ACK_WAIT;
            end
          end
        end
      end

      ACK_WAIT: begin
        if (cnt_q == C_DELAY_LAST) begin
          state_d = ACK_PULSE;
          ack_n_d = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ACK_PULSE: begin
        if (cnt_q == C_WIDTH_LAST) begin
          state_d    = SHIFT;
          ack_n_d    = 1'b1;
          cnt_d      = 8'd0;
          bit_idx_d  = 3'd0;
          byte_idx_d = w_byte_next;
          tx_d       = ps2_tx_byte(w_byte_next, PAD_ID, snap_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ABORT, DONE: begin
        dat_d   = 1'b1;
        ack_n_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        dat_d   = 1'b1;
        ack_n_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Host deselect wins over everything, including a byte completing now.
    if ((state_q != IDLE) && w_att_rise) begin
      state_d     = IDLE;
      dat_d       = 1'b1;
      ack_n_d     = 1'b1;
      busy_d      = 1'b0;
      cnt_d       = 8'd0;
      bit_idx_d   = 3'd0;
      byte_idx_d  = 3'd0;
      rx_d        = rx_q;
      cmd_byte_d  = cmd_byte_q;
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      byte_idx_q  <= 3'd0;
      bit_idx_q   <= 3'd0;
      cnt_q       <= 8'd0;
      tx_q        <= PS2_IDLE_BYTE;
      rx_q        <= 8'd0;
      snap_q      <= 16'hFFFF;
      dat_q       <= 1'b1;
      ack_n_q     <= 1'b1;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      snap_q      <= snap_d;
      dat_q       <= dat_d;
      ack_n_q     <= ack_n_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign ps_dat    = dat_q;
  assign ps_ack_n  = ack_n_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;

endmodule : ps2_pad_responder
`default_nettype wire

// File: tb/tb_ps2_pad_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_pad_responder
// Brief   : Host-side poll frames against a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_pad_responder;

  localparam int         ACK_DELAY = 100;
  localparam int         ACK_WIDTH = 150;
  localparam logic [7:0] PAD_ID    = 8'h41;
  localparam int         GAP       = 300;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic [15:0] buttons_n = 16'hFFFF;
  logic        att_n     = 1'b1;
  logic        pclk      = 1'b1;
  logic        pcmd      = 1'b1;
  logic        ps_dat, ps_ack_n, cmd_valid, busy;
  logic [7:0]  cmd_byte;

  ps2_pad_responder #(
    .ACK_DELAY (ACK_DELAY),
    .ACK_WIDTH (ACK_WIDTH),
    .PAD_ID    (PAD_ID)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .buttons_n (buttons_n),
    .ps_att_n  (att_n),
    .ps_clk    (pclk),
    .ps_cmd    (pcmd),
    .ps_dat    (ps_dat),
    .ps_ack_n  (ps_ack_n),
    .cmd_byte  (cmd_byte),
    .cmd_valid (cmd_valid),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int frame_no = 0;
  int half = 100;

  logic [7:0]  host_cmd [5];
  logic [15:0] mid_buttons = 16'h0000;
  bit          mid_change  = 1'b0;

  // Observed events, stamped with the clock-edge count.
  int         v_cyc [$];
  logic [7:0] v_byte [$];
  int         a_fall [$];
  int         a_width [$];
  int         rise8 [$];
  logic       ack_prev = 1'b1;
  int         fall_at  = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_byte.push_back(cmd_byte);
    end
    if (ack_prev === 1'b1 && ps_ack_n === 1'b0) begin
      fall_at = cyc;
      a_fall.push_back(cyc);
    end
    if (ack_prev === 1'b0 && ps_ack_n === 1'b1) a_width.push_back(cyc - fall_at);
    ack_prev = ps_ack_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (frame %0d): observed 0x%0h, expected 0x%0h", tag, frame_no, obs, exp);
    end
  endtask

  // mode 0: full frame; mode 1: release ATT before bit stop_bit of byte stop_byte;
  // mode 2: pulse resetn during the ACK following byte stop_byte-1.
  task automatic frame(input int mode, input int stop_byte, input int stop_bit);
    logic [15:0] snap;
    logic [7:0]  resp [5];
    int          nact, done, exp_valid, exp_acks, t;
    logic        exp_bit;
    bit          stop;
    frame_no++;
    v_cyc.delete(); v_byte.delete(); a_fall.delete(); a_width.delete(); rise8.delete();
    @(negedge clk);
    att_n = 1'b0;
    snap  = buttons_n;
    resp[0] = 8'hFF; resp[1] = PAD_ID; resp[2] = 8'h5A;
    resp[3] = snap[7:0]; resp[4] = snap[15:8];
    nact = (host_cmd[0] != 8'h01) ? 1 : (host_cmd[1] != 8'h42) ? 2 : 5;
    done = (mode == 0) ? 5 : stop_byte;
    repeat (2) @(negedge clk);
    chk("busy_latency_lo", busy, 1'b0);
    @(negedge clk);
    chk("busy_latency_hi", busy, 1'b1);
    stop = 1'b0;
    for (int b = 0; b < 5 && !stop; b++) begin
      if (b == 2 && mid_change) buttons_n = mid_buttons;
      for (int i = 0; i < 8 && !stop; i++) begin
        if (mode == 1 && b == stop_byte && i == stop_bit) begin
          stop = 1'b1;
        end else begin
          pclk = 1'b0;
          pcmd = host_cmd[b][i];
          repeat (half / 2) @(negedge clk);
          exp_bit = (b < nact) ? resp[b][i] : 1'b1;
          chk("dat_bit", ps_dat, exp_bit);
          repeat (half - half / 2) @(negedge clk);
          pclk = 1'b1;
          if (i == 7) rise8.push_back(cyc);
          repeat (half) @(negedge clk);
        end
      end
      if (!stop && mode == 2 && b == stop_byte - 1) begin
        t = 0;
        while (t < 600 && ps_ack_n !== 1'b0) begin
          @(negedge clk);
          t++;
        end
        chk("ack_seen_before_reset", ps_ack_n, 1'b0);
        repeat (20) @(negedge clk);
        chk("dat_during_ack", ps_dat, resp[b][7]);
        #3;
        resetn = 1'b0;
        att_n  = 1'b1;
        pclk   = 1'b1;
        #1;
        chk("rst_async_ack", ps_ack_n, 1'b1);
        chk("rst_async_dat", ps_dat, 1'b1);
        chk("rst_async_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_cmd_byte", cmd_byte, 8'h00);
        stop = 1'b1;
      end else if (!stop && b < 4) begin
        repeat (GAP) @(negedge clk);
      end
    end

    if (mode == 0) begin
      repeat (4) @(negedge clk);
      chk("end_busy", busy, 1'b0);
      chk("end_dat", ps_dat, 1'b1);
      chk("end_ack", ps_ack_n, 1'b1);
      att_n = 1'b1;
    end else if (mode == 1) begin
      att_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("release_busy_hold", busy, 1'b1);
      chk("release_dat_hold", ps_dat, resp[stop_byte][stop_bit - 1]);
      @(negedge clk);
      chk("release_dat", ps_dat, 1'b1);
      chk("release_ack", ps_ack_n, 1'b1);
      chk("release_busy", busy, 1'b0);
    end
    repeat (20) @(negedge clk);

    exp_valid = (nact < done) ? nact : done;
    if (nact == 5) exp_acks = (exp_valid < 4) ? exp_valid : 4;
    else           exp_acks = (exp_valid < nact - 1) ? exp_valid : nact - 1;
    chk("valid_count", v_cyc.size(), exp_valid);
    for (int k = 0; k < exp_valid && k < v_cyc.size(); k++) begin
      chk("cmd_byte", v_byte[k], host_cmd[k]);
      if (k < rise8.size()) chk("valid_latency", v_cyc[k] - rise8[k], 3);
    end
    chk("ack_count", a_fall.size(), exp_acks);
    chk("ack_width_count", a_width.size(), exp_acks);
    for (int k = 0; k < exp_acks && k < a_fall.size() && k < v_cyc.size(); k++)
      chk("ack_delay", a_fall[k] - v_cyc[k], ACK_DELAY + 1);
    for (int k = 0; k < a_width.size(); k++)
      if (!(mode == 2 && k == exp_acks - 1)) chk("ack_width", a_width[k], ACK_WIDTH);
  endtask

  task automatic good_cmds();
    host_cmd[0] = 8'h01;
    host_cmd[1] = 8'h42;
    for (int k = 2; k < 5; k++) host_cmd[k] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] x;
    repeat (3) @(negedge clk);
    chk("rst_dat", ps_dat, 1'b1);
    chk("rst_ack", ps_ack_n, 1'b1);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Reference poll at 250 kHz.
    half = 100;
    buttons_n = 16'hFEF7;
    host_cmd[0] = 8'h01; host_cmd[1] = 8'h42;
    host_cmd[2] = 8'h00; host_cmd[3] = 8'h00; host_cmd[4] = 8'h00;
    frame(0, 0, 0);

    half = 40;
    repeat (2) begin
      buttons_n = 16'($urandom);
      good_cmds();
      frame(0, 0, 0);
    end

    // Bad start bytes.
    good_cmds();
    host_cmd[0] = 8'h81;
    frame(0, 0, 0);
    do x = 8'($urandom); while (x == 8'h01);
    good_cmds();
    host_cmd[0] = x;
    frame(0, 0, 0);

    // Bad command byte.
    good_cmds();
    host_cmd[1] = 8'h43;
    buttons_n = 16'($urandom);
    frame(0, 0, 0);

    // Snapshot stays frozen while buttons change mid-frame.
    buttons_n   = 16'hFFFF;
    mid_buttons = 16'h0000;
    mid_change  = 1'b1;
    good_cmds();
    frame(0, 0, 0);
    mid_change = 1'b0;
    good_cmds();
    frame(0, 0, 0);

    // ATT released after 3 bits of byte 2, then a clean frame.
    buttons_n = 16'($urandom);
    good_cmds();
    frame(1, 2, 3);
    good_cmds();
    frame(0, 0, 0);

    // Reset pulse during the ACK after byte 2, then a clean frame.
    good_cmds();
    frame(2, 3, 0);
    buttons_n = 16'($urandom);
    good_cmds();
    frame(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ps2_pad_responder
`default_nettype wire
